// File: rtl/wrr_scheduler.sv
// Weighted round-robin packet grant scheduler with a run-time weight table.
// Optional per-queue granted-packet counters are built when WRR_SCHED_STATS_EN is defined.
module wrr_scheduler #(
  parameter int NUM_QUEUES     = 8,
  parameter int WEIGHT_WIDTH   = 7,
  parameter int DEFAULT_WEIGHT = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_QUEUES-1:0]         req,
  input  logic                          pkt_done,
  output logic [NUM_QUEUES-1:0]         grant,
  output logic                          grant_valid,
  input  logic                          cfg_wr_en,
  input  logic [$clog2(NUM_QUEUES)-1:0] cfg_wr_addr,
  input  logic [WEIGHT_WIDTH-1:0]       cfg_wr_data,
  input  logic [$clog2(NUM_QUEUES):0]   cfg_rd_addr,
  output logic [15:0]                   cfg_rd_data
);

  localparam int AW = $clog2(NUM_QUEUES);
  localparam int SW = AW + 1;
  localparam logic [WEIGHT_WIDTH-1:0] DEF_W     = WEIGHT_WIDTH'(DEFAULT_WEIGHT);
  localparam logic [AW-1:0]           LAST_Q    = AW'(NUM_QUEUES - 1);
  localparam logic [SW-1:0]           SCAN_FULL = SW'(NUM_QUEUES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SELECT,
    S_GRANT,
    S_ADVANCE
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nx;
  logic [AW-1:0]           r_ptr;
  logic [SW-1:0]           r_scan_cnt;
  logic [WEIGHT_WIDTH-1:0] r_weight [NUM_QUEUES];
  logic [WEIGHT_WIDTH-1:0] r_credit [NUM_QUEUES];
  logic [NUM_QUEUES-1:0]   r_grant;
  logic                    r_grant_valid;

  logic                    w_issue;
  logic                    w_done;
  logic                    w_advance;
  logic                    w_exhaust;
  logic                    w_reload;
  logic [WEIGHT_WIDTH-1:0] w_credit_cur;
  logic [WEIGHT_WIDTH-1:0] w_credit_dec;
  logic [SW-1:0]           w_scan_inc;
  logic [NUM_QUEUES-1:0]   w_onehot;
  logic [15:0]             w_stat_rd;

  assign w_credit_cur = r_credit[r_ptr];
  assign w_credit_dec = w_credit_cur - 1'b1;
  assign w_scan_inc   = r_scan_cnt + 1'b1;
  assign w_exhaust    = (w_scan_inc == SCAN_FULL);
  assign w_onehot     = {{(NUM_QUEUES-1){1'b0}}, 1'b1} << r_ptr;

  always_comb begin
    w_state_nx = r_state;
    w_issue    = 1'b0;
    w_done     = 1'b0;
    w_advance  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|req) w_state_nx = S_SELECT;
      end
      S_SELECT: begin
        if (req[r_ptr] && (w_credit_cur != '0)) begin
          w_issue    = 1'b1;
          w_state_nx = S_GRANT;
        end else begin
          w_state_nx = S_ADVANCE;
        end
      end
      S_GRANT: begin
        if (pkt_done) begin
          w_done     = 1'b1;
          w_state_nx = (w_credit_dec == '0) ? S_ADVANCE : S_SELECT;
        end
      end
      S_ADVANCE: begin
        w_advance  = 1'b1;
        w_state_nx = w_exhaust ? S_IDLE : S_SELECT;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // A full unsuccessful scan also refills credits so an idle restart sees fresh budgets.
  assign w_reload = w_advance && ((r_ptr == LAST_Q) || w_exhaust);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      r_ptr         <= '0;
      r_scan_cnt    <= '0;
      for (int i = 0; i < NUM_QUEUES; i++) begin
        r_weight[i] <= DEF_W;
        r_credit[i] <= DEF_W;
      end
    end else begin
      if (cfg_wr_en) r_weight[cfg_wr_addr] <= cfg_wr_data;
      if (w_issue) begin
        r_grant       <= w_onehot;
        r_grant_valid <= 1'b1;
        r_scan_cnt    <= '0;
      end
      if (w_done) begin
        r_grant           <= '0;
        r_grant_valid     <= 1'b0;
        r_credit[r_ptr]   <= w_credit_dec;
      end
      if (w_advance) begin
        r_ptr      <= r_ptr + 1'b1;
        r_scan_cnt <= w_exhaust ? '0 : w_scan_inc;
      end
      // Reload reads the registered weights, so a same-cycle write lands one round later.
      if (w_reload) begin
        for (int i = 0; i < NUM_QUEUES; i++) r_credit[i] <= r_weight[i];
      end
    end
  end

`ifdef WRR_SCHED_STATS_EN
  logic [15:0] r_pkt_cnt [NUM_QUEUES];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_QUEUES; i++) r_pkt_cnt[i] <= '0;
    end else if (w_done) begin
      r_pkt_cnt[r_ptr] <= r_pkt_cnt[r_ptr] + 16'd1;
    end
  end

  assign w_stat_rd = r_pkt_cnt[cfg_rd_addr[AW-1:0]];
`else
  assign w_stat_rd = '0;
`endif

  assign cfg_rd_data = cfg_rd_addr[AW] ? w_stat_rd
                                       : 16'(r_weight[cfg_rd_addr[AW-1:0]]);
  assign grant       = r_grant;
  assign grant_valid = r_grant_valid;

endmodule

// File: tb/tb_wrr_scheduler.sv
// Randomized bench for wrr_scheduler against a time-stamped transaction model.
module tb_wrr_scheduler;

  localparam int NQ = 8;
  localparam int WW = 7;
`ifdef WRR_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [NQ-1:0] req;
  logic          pkt_done;
  logic [NQ-1:0] grant;
  logic          grant_valid;
  logic          cfg_wr_en;
  logic [2:0]    cfg_wr_addr;
  logic [WW-1:0] cfg_wr_data;
  logic [3:0]    cfg_rd_addr;
  logic [15:0]   cfg_rd_data;

  wrr_scheduler #(.NUM_QUEUES(NQ), .WEIGHT_WIDTH(WW), .DEFAULT_WEIGHT(1)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .pkt_done    (pkt_done),
    .grant       (grant),
    .grant_valid (grant_valid),
    .cfg_wr_en   (cfg_wr_en),
    .cfg_wr_addr (cfg_wr_addr),
    .cfg_wr_data (cfg_wr_data),
    .cfg_rd_addr (cfg_rd_addr),
    .cfg_rd_data (cfg_rd_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  // model state: weights, credits, pointer, per-queue packet counts
  int m_w [NQ];
  int m_c [NQ];
  int m_cnt [NQ];
  int m_p;
  int m_idle_from;

  int g_obs_q, g_obs_t, g_done_d, g_pred_q, g_issue_k;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic void m_reset();
    for (int i = 0; i < NQ; i++) begin
      m_w[i] = 1; m_c[i] = 1; m_cnt[i] = 0;
    end
    m_p = 0;
  endfunction

  function automatic void m_reload();
    for (int i = 0; i < NQ; i++) m_c[i] = m_w[i];
  endfunction

  // Walk the queues starting with a selection decided at edge t0. Each skip costs two
  // edges; a full lap without a grant drops to idle (one extra edge to re-arm).
  // q >= 0: grant visible after edge t; q == -1: idle from edge t; q == -2: never.
  task automatic m_scan(input int t0, input int s0, input logic [NQ-1:0] rq,
                        output int q, output int t);
    int  tt = t0;
    int  s  = s0;
    bit  fin = 1'b0;
    q = -2; t = 0;
    for (int it = 0; it < 4*NQ && !fin; it++) begin
      if (rq[m_p] && m_c[m_p] > 0) begin
        q = m_p; t = tt; fin = 1'b1;
      end else begin
        if (m_p == NQ-1) m_reload();
        m_p = (m_p + 1) % NQ;
        s++;
        if (s == NQ) begin
          m_reload();
          s = 0;
          if (rq == '0) begin
            q = -1; t = tt + 2; fin = 1'b1;
          end else tt = tt + 3;
        end else tt = tt + 2;
      end
    end
  endtask

  task automatic m_done(input int d, input logic [NQ-1:0] rq, output int q, output int t);
    m_cnt[m_p] = (m_cnt[m_p] + 1) % 65536;
    m_c[m_p]   = m_c[m_p] - 1;
    if (m_c[m_p] > 0) m_scan(d + 1, 0, rq, q, t);
    else begin
      if (m_p == NQ-1) m_reload();
      m_p = (m_p + 1) % NQ;
      m_scan(d + 2, 1, rq, q, t);
    end
  endtask

  function automatic int gidx(input logic [NQ-1:0] g);
    int r = -1;
    for (int i = 0; i < NQ; i++) if (g[i]) r = (r == -1) ? i : -3;
    return r;
  endfunction

  function automatic logic [NQ-1:0] pick_req(input bit nonzero);
    logic [NQ-1:0] r;
    for (int tries = 0; tries < 20; tries++) begin
      if (!nonzero && $urandom_range(0, 5) == 0) return '0;
      r = NQ'($urandom);
      for (int i = 0; i < NQ; i++) if (r[i] && m_w[i] > 0) return r;
    end
    for (int i = 0; i < NQ; i++) if (m_w[i] > 0) return NQ'(1) << i;
    return '0;
  endfunction

  task automatic wait_grant(input int q_pred, input int t_pred);
    int t_obs = -1;
    bit seen  = 1'b0;
    g_pred_q = q_pred;
    g_obs_q  = -1;
    if (q_pred >= 0) begin
      while (cyc <= t_pred + 4 && t_obs < 0) begin
        if (grant_valid) t_obs = cyc;
        else begin
          pkt_done = ($urandom_range(0, 3) == 0);
          step();
        end
      end
      pkt_done = 1'b0;
      check_val("gnt_time", t_obs, t_pred);
      check_val("gnt_vec", {grant_valid, grant}, {1'b1, NQ'(1) << q_pred});
      g_obs_q = gidx(grant);
      g_obs_t = t_obs;
    end else if (q_pred == -1) begin
      while (cyc < t_pred) begin
        if (grant_valid) seen = 1'b1;
        pkt_done = ($urandom_range(0, 3) == 0);
        step();
      end
      pkt_done = 1'b0;
      if (grant_valid) seen = 1'b1;
      check_val("idle_quiet", seen, 0);
      m_idle_from = t_pred;
    end
  endtask

  task automatic issue_from_idle(input logic [NQ-1:0] rq);
    int q, t;
    while (cyc + 1 < m_idle_from) step();
    req = rq;
    g_issue_k = cyc;
    m_scan(cyc + 2, 0, rq, q, t);
    wait_grant(q, t);
  endtask

  task automatic serve(input int hold, input logic [NQ-1:0] new_rq,
                       input bit do_wr, input int wq, input int wv);
    logic [NQ-1:0] exp_g;
    int q, t;
    exp_g = NQ'(1) << m_p;
    for (int i = 0; i < hold; i++) begin
      req = NQ'($urandom);
      step();
      check_val("hold", {grant_valid, grant}, {1'b1, exp_g});
    end
    pkt_done = 1'b1;
    req      = new_rq;
    if (do_wr) begin
      cfg_wr_en = 1'b1; cfg_wr_addr = 3'(wq); cfg_wr_data = WW'(wv);
      m_w[wq]   = wv;
    end
    step();
    pkt_done  = 1'b0;
    cfg_wr_en = 1'b0;
    g_done_d  = cyc;
    check_val("release", {grant_valid, grant}, 0);
    m_done(g_done_d, new_rq, q, t);
    g_pred_q = q;
    if (q != -2) wait_grant(q, t);
  endtask

  task automatic wr_weight(input int q, input int v);
    cfg_wr_en = 1'b1; cfg_wr_addr = 3'(q); cfg_wr_data = WW'(v);
    m_w[q] = v;
    step();
    cfg_wr_en = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [3:0] addr, input logic [31:0] exp);
    cfg_rd_addr = addr;
    #1;
    check_val(tag, cfg_rd_data, exp);
  endtask

  task automatic do_reset();
    reset = 1'b0; req = '0; pkt_done = 1'b0; cfg_wr_en = 1'b0;
    step(); step();
    reset = 1'b1;
    m_reset();
    m_idle_from = cyc;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int seq [8];
    int exp_seq [8];
    int bad;
    bit seen;
    bit granted;
    logic [NQ-1:0] rq;
    int wq, wv;
    bit do_wr;

    reset = 1'b0; req = '0; pkt_done = 1'b0;
    cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_data = '0; cfg_rd_addr = '0;
    step(); step();
    check_val("rst_grant", grant, 0);
    check_val("rst_valid", grant_valid, 0);
    reset = 1'b1;
    m_reset();
    m_idle_from = cyc;

    // no requests: nothing granted; default weights read back
    for (int i = 0; i < 10; i++) begin
      pkt_done = (i % 3 == 0);
      step();
      check_val("idle_valid", {grant_valid, grant}, 0);
    end
    pkt_done = 1'b0;
    for (int i = 0; i < NQ; i++) begin
      rd_check("rst_weight", 4'(i), 1);
      step();
    end
    rd_check("rst_stat", 4'b1010, 0);
    step();

    // lone request on q2 from ptr 0, then five packets on q2
    issue_from_idle(8'b0000_0100);
    check_val("q2_latency", g_obs_t - g_issue_k, 6);
    for (int i = 0; i < 4; i++) serve($urandom_range(0, 3), 8'b0000_0100, 1'b0, 0, 0);
    serve(1, 8'b0, 1'b0, 0, 0);
    rd_check("q2_stats", 4'b1010, STATS ? 5 : 0);
    step();

    // weights q0=1 q1=2 rest 0, req held at 2'b11
    do_reset();
    for (int i = 0; i < NQ; i++) wr_weight(i, (i == 0) ? 1 : (i == 1) ? 2 : 0);
    rd_check("w1_rb", 4'd1, 2);
    issue_from_idle(8'b0000_0011);
    seq[0] = g_obs_q;
    for (int i = 1; i < 8; i++) begin
      serve(2, 8'b0000_0011, 1'b0, 0, 0);
      seq[i] = g_obs_q;
      if (i == 4) check_val("q1_regrant_gap", g_obs_t - (g_done_d - 1), 2);
    end
    exp_seq = '{0, 1, 0, 1, 1, 0, 1, 1};
    for (int i = 0; i < 8; i++) check_val("wrr_order", seq[i], exp_seq[i]);

    // q3 disabled while it holds its last credit
    do_reset();
    issue_from_idle(8'b0000_1000);
    serve(1, 8'b0000_1000, 1'b1, 3, 0);
    check_val("q3_pred_never", g_pred_q, -2);
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (grant_valid) seen = 1'b1;
    end
    check_val("q3_skipped", seen, 0);
    rd_check("w3_rb", 4'd3, 0);
    req = 8'b0001_0000;
    bad = 1;
    for (int i = 0; i < 100 && bad == 1; i++) begin
      step();
      if (grant_valid) bad = 0;
    end
    check_val("q4_gnt", {grant_valid, grant}, {1'b1, 8'b0001_0000});

    // asynchronous reset in the middle of the q4 packet
    #2 reset = 1'b0;
    #1;
    check_val("arst_grant", grant, 0);
    check_val("arst_valid", grant_valid, 0);
    req = '0;
    step(); step();
    reset = 1'b1;
    m_reset();
    m_idle_from = cyc;
    rd_check("w3_after_rst", 4'd3, 1);
    step();
    issue_from_idle(8'b0000_0001);
    check_val("ptr0_latency", g_obs_t - g_issue_k, 2);

    // randomized traffic with live weight updates
    granted = 1'b1;
    for (int n = 0; n < 150; n++) begin
      if (!granted) begin
        rq = pick_req(1'b1);
        if (rq == '0) begin
          wr_weight($urandom_range(0, NQ-1), $urandom_range(1, 3));
          rq = pick_req(1'b1);
        end
        issue_from_idle(rq);
      end
      wq = $urandom_range(0, NQ-1);
      rd_check("w_rb", 4'(wq), m_w[wq]);
      do_wr = ($urandom_range(0, 4) == 0);
      wq    = $urandom_range(0, NQ-1);
      wv    = $urandom_range(0, 3);
      if (do_wr) m_w[wq] = wv;
      rq = pick_req(1'b0);
      serve($urandom_range(0, 3), rq, do_wr, wq, wv);
      granted = (g_pred_q >= 0);
      if (g_pred_q == -2) check_val("rand_pred", g_pred_q, 0);
      if (!granted) step();
    end

    for (int i = 0; i < NQ; i++) begin
      rd_check("final_stat", 4'(8 + i), STATS ? m_cnt[i] : 0);
      rd_check("final_w", 4'(i), m_w[i]);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
